// File: rtl/ui_pkg.sv
// Shared definitions for the user-interface board blocks: key-id width helper,
// event-channel FSM encoding and the default auto-repeat timing.
package ui_pkg;

    localparam logic [23:0] REPEAT_DELAY_DEF  = 24'd5_000_000;
    localparam logic [23:0] REPEAT_PERIOD_DEF = 24'd1_000_000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_e;

    function automatic int key_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin pick: first set request at or after ptr_i,
// wrapping past N-1 back to 0.
module rr_arbiter
    import ui_pkg::*;
#(
    parameter int N = 4,
    parameter int W = key_id_w(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] gnt_o,
    output logic         any_o
);

    int         idx_int;
    logic [W-1:0] idx;

    always_comb begin
        gnt_o   = '0;
        any_o   = 1'b0;
        idx_int = 0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx_int = int'(ptr_i) + i;
            if (idx_int >= N) idx_int = idx_int - N;
            idx = W'(idx_int);
            if (!any_o && req_i[idx]) begin
                any_o = 1'b1;
                gnt_o = idx;
            end
        end
    end

endmodule

// File: rtl/key_event_scheduler.sv
// Serialises key press edges and hold-repeat ticks from debounced key levels
// into one valid/ready event stream, round-robin shared, with sticky overrun.
module key_event_scheduler
    import ui_pkg::*;
#(
    parameter int          N_KEYS        = 4,
    parameter logic [23:0] REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter logic [23:0] REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter bit          REPEAT_EN     = 1'b1,
    localparam int         ID_W          = key_id_w(N_KEYS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_KEYS-1:0] i_key_level,
    output logic              o_evt_valid,
    input  logic              i_evt_ready,
    output logic [ID_W-1:0]   o_evt_id,
    output logic              o_evt_repeat,
    output logic [N_KEYS-1:0] o_pending,
    output logic              o_overrun,
    input  logic              i_clr_overrun
);

    state_e            state_q;
    logic [N_KEYS-1:0] key_q;
    logic              armed_q;
    logic [N_KEYS-1:0] pend_q, pend_d;
    logic [N_KEYS-1:0] rep_q, rep_d;
    logic [N_KEYS-1:0] rise, ovr_hit, gnt_mask;
    logic              ovr_d;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any, do_grant;
    logic              tmr_act_q, tmr_act_d;
    logic [23:0]       tmr_cnt_q, tmr_cnt_d;
    logic [ID_W-1:0]   rep_key_q, rep_key_d;
    logic              tick;

    rr_arbiter #(.N(N_KEYS), .W(ID_W)) u_arb (
        .req_i (pend_q),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt_idx),
        .any_o (gnt_any)
    );

    // The first edge after reset only primes key_q, so keys held through
    // reset do not look like fresh presses.
    assign rise      = armed_q ? (i_key_level & ~key_q) : '0;
    assign do_grant  = (state_q == ST_IDLE) && gnt_any;
    assign gnt_mask  = do_grant ? (N_KEYS'(1) << gnt_idx) : '0;
    assign o_pending = pend_q;

    always_comb begin
        tick      = 1'b0;
        tmr_act_d = tmr_act_q;
        tmr_cnt_d = tmr_cnt_q;
        rep_key_d = rep_key_q;
        if (tmr_act_q) begin
            if (!i_key_level[rep_key_q]) begin
                tmr_act_d = 1'b0;
            end else if (tmr_cnt_q == 24'd0) begin
                tick      = 1'b1;
                tmr_cnt_d = REPEAT_PERIOD - 24'd1;
            end else begin
                tmr_cnt_d = tmr_cnt_q - 24'd1;
            end
        end
        // A press grant retargets the timer; a repeat grant of another key kills it.
        if (do_grant) begin
            if (!rep_q[gnt_idx]) begin
                tmr_act_d = REPEAT_EN;
                tmr_cnt_d = REPEAT_DELAY - 24'd1;
                rep_key_d = gnt_idx;
            end else if (gnt_idx != rep_key_q) begin
                tmr_act_d = 1'b0;
            end
        end
    end

    always_comb begin
        pend_d = pend_q & ~gnt_mask;
        rep_d  = rep_q & ~gnt_mask;
        if (tick && !pend_d[rep_key_q]) begin
            pend_d[rep_key_q] = 1'b1;
            rep_d[rep_key_q]  = 1'b1;
        end
        pend_d  = pend_d | rise;
        rep_d   = rep_d & ~rise;
        ovr_hit = rise & pend_q & ~gnt_mask;
        ovr_d   = i_clr_overrun ? 1'b0 : o_overrun;
        if (|ovr_hit) ovr_d = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            key_q     <= '0;
            armed_q   <= 1'b0;
            pend_q    <= '0;
            rep_q     <= '0;
            o_overrun <= 1'b0;
            tmr_act_q <= 1'b0;
            tmr_cnt_q <= '0;
            rep_key_q <= '0;
        end else begin
            key_q     <= i_key_level;
            armed_q   <= 1'b1;
            pend_q    <= pend_d;
            rep_q     <= rep_d;
            o_overrun <= ovr_d;
            tmr_act_q <= tmr_act_d;
            tmr_cnt_q <= tmr_cnt_d;
            rep_key_q <= rep_key_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            o_evt_valid  <= 1'b0;
            o_evt_id     <= '0;
            o_evt_repeat <= 1'b0;
            rr_ptr_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (do_grant) begin
                        o_evt_valid  <= 1'b1;
                        o_evt_id     <= gnt_idx;
                        o_evt_repeat <= rep_q[gnt_idx];
                        rr_ptr_q     <= (gnt_idx == ID_W'(N_KEYS - 1)) ? '0 : gnt_idx + 1'b1;
                        state_q      <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (i_evt_ready) begin
                        o_evt_valid <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/key_event_scheduler.md
Name: key_event_scheduler

Overview:
- Collects debounced level outputs from up to N key debouncers (POSEDGE=0 mode) on the user-interface board.
- Turns press edges and hold-repeat ticks into a single serialized event stream for the CPU user-interface port, using a valid/ready handshake.
- Shares the single event channel between keys by round-robin arbitration and flags lost events.

Parameters:
- N_KEYS, 4, number of debounced key inputs (2..16).
- REPEAT_DELAY, 24'd5_000_000, cycles a granted key must stay held before its first repeat event.
- REPEAT_PERIOD, 24'd1_000_000, cycles between subsequent repeat events.
- REPEAT_EN, 1'b1, 0 disables all repeat generation.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_key_level  in  N_KEYS  debounced key levels, 1 = pressed.
- o_evt_valid  out  1  event available.
- i_evt_ready  in  1  consumer accepts event.
- o_evt_id  out  clog2(N_KEYS)  index of the key that caused the event.
- o_evt_repeat  out  1  0 = press edge, 1 = auto-repeat.
- o_pending  out  N_KEYS  per-key queued-event bits (status).
- o_overrun  out  1  sticky: an event was dropped.
- i_clr_overrun  in  1  synchronous clear of o_overrun.

Behaviour:
- Reset is asynchronous and active-high. Reset values: key_q=0, pending=0, pend_rep=0, o_evt_valid=0, o_evt_id=0, o_evt_repeat=0, o_overrun=0, rr_ptr=0, repeat timer idle, state=IDLE.
- Edge detect:
  - key_q registers i_key_level every cycle.
  - rise[k] = i_key_level[k] & ~key_q[k].
  - On the next edge, rise[k] sets pending[k] and clears pend_rep[k].
- FSM:
  - IDLE: if pending != 0, grant the first set bit searching from rr_ptr upward with wrap-around. On that edge: load o_evt_id and o_evt_repeat = pend_rep[g], clear pending[g], set o_evt_valid, set rr_ptr = g+1 (wraps to 0 after N_KEYS-1), go to OFFER.
  - OFFER: hold o_evt_valid, o_evt_id and o_evt_repeat stable. When i_evt_ready=1, drop o_evt_valid next edge and go to IDLE. No back-to-back grant in the same cycle.
  - Throughput is 1 event per 2 cycles maximum.
- Latency: a rising edge on i_key_level at edge t gives pending at t+1 and o_evt_valid at t+2, when IDLE with no other pending key.
- Overrun:
  - A rise on key k while pending[k]=1 sets o_overrun and the event merges (pending stays 1, pend_rep cleared).
  - A repeat tick while pending[k]=1 is dropped silently, with no overrun.
- Simultaneous events:
  - Rise on k in the same cycle as a grant of k: the grant takes the old event and pending[k] ends at 1 (set wins). No overrun.
  - i_clr_overrun together with a new overrun condition: the set wins.
- Repeat (REPEAT_EN=1):
  - A single shared timer tracks the last granted key (rep_key).
  - On grant of a press event: timer loads REPEAT_DELAY-1 and becomes active.
  - Active timer counts down each cycle. At 0 with i_key_level[rep_key]=1: set pending[rep_key] and pend_rep[rep_key], reload REPEAT_PERIOD-1.
  - Timer goes idle when i_key_level[rep_key]=0 or when any other key is granted.
  - Grant of a repeat event does not reload the timer.
- Width rules: the timer is 24 bits. Parameters must be nonzero and fit 24 bits; REPEAT_DELAY=1 means a tick on the cycle after grant.
- o_pending mirrors the pending register directly.

Decomposition:
- Shared package ui_pkg holds:
  - KEY_ID_W function (clog2)
  - FSM state encoding (IDLE, OFFER)
  - default REPEAT_DELAY and REPEAT_PERIOD constants, also used by the debouncer's CNT_MAX documentation.
- One natural sub-module, rr_arbiter:
  - parameterised N-way round-robin priority pick.
  - Inputs: req vector and ptr. Outputs: grant index and any-valid.
  - Purely combinational; reused later for UART and LED resource sharing.

Test Plan:
- Single press: after reset, raise i_key_level[2] with i_evt_ready=1 -> o_evt_valid high exactly 2 cycles later with o_evt_id=2 and o_evt_repeat=0, for one cycle; o_pending=0 afterwards.
- Simultaneous press: raise keys 0,1,3 in the same cycle with rr_ptr=0 and ready=1 -> events in order 0, 1, 3, spaced 2 cycles apart. Then raise 0 and 3 together -> order 0, 3, starting from rr_ptr=... Correction: rr_ptr is 0 after granting 3 (3+1 wraps to 0 with N_KEYS=4), so expected order is 0 then 3.
- Backpressure and overrun: hold i_evt_ready=0 with key 1 offered, then pulse key 1 twice (release between) -> o_overrun=1, o_pending[1]=1, o_evt_id stays 1 and stable. After ready, exactly one more key-1 event; i_clr_overrun clears the flag.
- Repeat: REPEAT_DELAY=10, REPEAT_PERIOD=4, hold key 0 for 30 cycles with ready=1 -> press event, then repeat events (o_evt_repeat=1) with pending set at grant+10 and every 4 cycles. Releasing the key stops repeats immediately.
- Repeat preempted: hold key 0 and press key 2 before the delay expires -> key 2 event, then no repeats for key 0 thereafter.
- Async reset mid-OFFER: assert i_rst with o_evt_valid=1 -> o_evt_valid, o_pending and o_overrun go 0 without waiting for a clock edge. Keys still held at deassert generate no event until a new rising edge.
